// File: rtl/hangman_pkg.sv
// Shared types and constants for the word-guessing game engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hangman_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      RES_HIT     = 2'd0,
      RES_MISS    = 2'd1,
      RES_REPEAT  = 2'd2,
      RES_INVALID = 2'd3
   } result_e;

   localparam int ASCII_A          = 'h41;
   localparam int ASCII_a          = 'h61;
   localparam int ASCII_UNDERSCORE = 'h5F;
   localparam int ALPHA_N          = 26;

endpackage

// File: rtl/char_classify.sv
// Classifies one ASCII code: letter flag, upper-case fold, 0..25 letter index.
// Latency: combinational.
// Backpressure: none.
// Ports: code in; is_letter, folded, idx out (idx meaningful only when is_letter).
module char_classify
   import hangman_pkg::*;
#(
   parameter int CHAR_W = 7
) (
   input  logic [CHAR_W-1:0] code,
   output logic              is_letter,
   output logic [CHAR_W-1:0] folded,
   output logic [4:0]        idx
);

   logic is_upper;
   logic is_lower;

   always_comb begin
      is_upper  = (code >= CHAR_W'(ASCII_A)) && (code <= CHAR_W'(ASCII_A + ALPHA_N - 1));
      is_lower  = (code >= CHAR_W'(ASCII_a)) && (code <= CHAR_W'(ASCII_a + ALPHA_N - 1));
      is_letter = is_upper | is_lower;
      folded    = is_lower ? (code - CHAR_W'(ASCII_a - ASCII_A)) : code;
      idx       = 5'(folded - CHAR_W'(ASCII_A));
   end

endmodule

// File: rtl/hangman_core.sv
// Word-guessing game engine: holds a secret word, scores guesses, tracks lives.
// Latency: guess accepted at edge N -> result_valid in cycle N+1, won/lost after edge N+1.
// Backpressure: guess_ready only in PLAY, so at most one guess every 2 cycles.
// Ports: clk/reset_n; restart, load_valid/word_in, guess_valid/guess_char/guess_ready in;
//        disp_chars, revealed, lives, result_valid/result, won, lost out.
module hangman_core
   import hangman_pkg::*;
#(
   parameter int WORD_LEN  = 7,
   parameter int CHAR_W    = 7,
   parameter int MAX_LIVES = 7,
   parameter int LIFE_W    = 3
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       restart,
   input  logic                       load_valid,
   input  logic [WORD_LEN*CHAR_W-1:0] word_in,
   input  logic                       guess_valid,
   input  logic [CHAR_W-1:0]          guess_char,
   output logic                       guess_ready,
   output logic [WORD_LEN*CHAR_W-1:0] disp_chars,
   output logic [WORD_LEN-1:0]        revealed,
   output logic [LIFE_W-1:0]          lives,
   output logic                       result_valid,
   output logic [1:0]                 result,
   output logic                       won,
   output logic                       lost
);

   typedef logic [WORD_LEN-1:0][CHAR_W-1:0] word_t;

   state_e                   state_q, state_d;
   word_t                    word_q, word_d;
   word_t                    disp_q, disp_d;
   logic [WORD_LEN-1:0]      revealed_q, revealed_d;
   logic [ALPHA_N-1:0]       used_q, used_d;
   // Letters occurring anywhere in the word; decides HIT vs MISS in one lookup.
   logic [ALPHA_N-1:0]       present_q, present_d;
   logic [LIFE_W-1:0]        lives_q, lives_d;
   logic                     result_vld_q, result_vld_d;
   result_e                  result_q, result_d;

   logic [WORD_LEN-1:0]      w_letter;
   word_t                    w_fold;
   logic [WORD_LEN-1:0][4:0] w_idx;
   logic                     g_letter;
   logic [CHAR_W-1:0]        g_fold;
   logic [4:0]               g_idx;
   logic [WORD_LEN-1:0]      match;

   for (genvar i = 0; i < WORD_LEN; i++) begin : g_word_cls
      char_classify #(.CHAR_W(CHAR_W)) u_word_cls (
         .code      (word_in[i*CHAR_W +: CHAR_W]),
         .is_letter (w_letter[i]),
         .folded    (w_fold[i]),
         .idx       (w_idx[i])
      );
   end

   char_classify #(.CHAR_W(CHAR_W)) u_guess_cls (
      .code      (guess_char),
      .is_letter (g_letter),
      .folded    (g_fold),
      .idx       (g_idx)
   );

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      revealed_d   = revealed_q;
      used_d       = used_q;
      present_d    = present_q;
      lives_d      = lives_q;
      result_vld_d = 1'b0;
      result_d     = result_q;
      disp_d       = disp_q;

      // Word is stored folded, so a folded letter guess never equals a non-letter slot.
      for (int i = 0; i < WORD_LEN; i++) begin
         match[i] = (word_q[i] == g_fold);
      end

      if (restart) begin
         state_d    = ST_IDLE;
         word_d     = '0;
         revealed_d = '0;
         used_d     = '0;
         present_d  = '0;
         lives_d    = '0;
         result_d   = RES_HIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_valid) begin
                  word_d     = w_fold;
                  revealed_d = ~w_letter;
                  used_d     = '0;
                  present_d  = '0;
                  for (int i = 0; i < WORD_LEN; i++) begin
                     if (w_letter[i]) present_d[w_idx[i]] = 1'b1;
                  end
                  lives_d    = LIFE_W'(MAX_LIVES);
                  state_d    = ST_CHECK;
               end
            end
            ST_PLAY: begin
               if (guess_valid) begin
                  result_vld_d = 1'b1;
                  state_d      = ST_CHECK;
                  if (!g_letter) begin
                     result_d = RES_INVALID;
                  end else if (used_q[g_idx]) begin
                     result_d = RES_REPEAT;
                  end else if (present_q[g_idx]) begin
                     result_d       = RES_HIT;
                     used_d[g_idx]  = 1'b1;
                     revealed_d     = revealed_q | match;
                  end else begin
                     // CHECK leaves PLAY only with lives >= 1, so this cannot wrap.
                     result_d       = RES_MISS;
                     used_d[g_idx]  = 1'b1;
                     lives_d        = lives_q - 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (&revealed_q)           state_d = ST_WIN;
               else if (lives_q == '0)    state_d = ST_LOSE;
               else                       state_d = ST_PLAY;
            end
            default: ;
         endcase
      end

      // Display follows the next-state view so it lines up with lost/revealed.
      for (int i = 0; i < WORD_LEN; i++) begin
         disp_d[i] = ((state_d == ST_LOSE) || revealed_d[i]) ? word_d[i]
                                                             : CHAR_W'(ASCII_UNDERSCORE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         word_q       <= '0;
         disp_q       <= {WORD_LEN{CHAR_W'(ASCII_UNDERSCORE)}};
         revealed_q   <= '0;
         used_q       <= '0;
         present_q    <= '0;
         lives_q      <= '0;
         result_vld_q <= 1'b0;
         result_q     <= RES_HIT;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         disp_q       <= disp_d;
         revealed_q   <= revealed_d;
         used_q       <= used_d;
         present_q    <= present_d;
         lives_q      <= lives_d;
         result_vld_q <= result_vld_d;
         result_q     <= result_d;
      end
   end

   assign guess_ready  = (state_q == ST_PLAY);
   assign won          = (state_q == ST_WIN);
   assign lost         = (state_q == ST_LOSE);
   assign disp_chars   = disp_q;
   assign revealed     = revealed_q;
   assign lives        = lives_q;
   assign result_valid = result_vld_q;
   assign result       = result_q;

endmodule

// File: tb/tb_hangman_core.sv
// Directed bench for hangman_core: load/guess/restart scenarios with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_hangman_core;

   localparam int WL = 7;
   localparam int CW = 7;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             restart = 1'b0;
   logic             load_valid = 1'b0;
   logic [WL*CW-1:0] word_in = '0;
   logic             guess_valid = 1'b0;
   logic [CW-1:0]    guess_char = '0;
   logic             guess_ready;
   logic [WL*CW-1:0] disp_chars;
   logic [WL-1:0]    revealed;
   logic [2:0]       lives;
   logic             result_valid;
   logic [1:0]       result;
   logic             won;
   logic             lost;

   int n_chk  = 0;
   int n_pass = 0;

   hangman_core #(.WORD_LEN(WL), .CHAR_W(CW), .MAX_LIVES(7), .LIFE_W(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .restart      (restart),
      .load_valid   (load_valid),
      .word_in      (word_in),
      .guess_valid  (guess_valid),
      .guess_char   (guess_char),
      .guess_ready  (guess_ready),
      .disp_chars   (disp_chars),
      .revealed     (revealed),
      .lives        (lives),
      .result_valid (result_valid),
      .result       (result),
      .won          (won),
      .lost         (lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // First character of the string lands in slot 0 (LSBs).
   function automatic logic [WL*CW-1:0] pk(input string s);
      logic [WL*CW-1:0] r;
      r = '0;
      for (int i = 0; i < WL; i++) r[i*CW +: CW] = CW'(s[i]);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input string s);
      word_in    = pk(s);
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("ld_rdy_check", guess_ready, 0);
      step();
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("rst_lives", lives, 0);
      chk("rst_rdy", guess_ready, 0);
      chk("rst_rev", revealed, 0);
   endtask

   task automatic guess(input byte c, input logic [1:0] er, input int el, input logic [6:0] erev);
      chk("g_rdy", guess_ready, 1);
      guess_char  = c[CW-1:0];
      guess_valid = 1'b1;
      step();
      guess_valid = 1'b0;
      chk("g_vld", result_valid, 1);
      chk("g_res", result, er);
      chk("g_lives", lives, el);
      chk("g_rev", revealed, erev);
      chk("g_not_done", won | lost, 0);
      chk("g_rdy_check", guess_ready, 0);
      step();
      chk("g_pulse_end", result_valid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      string misses;
      misses = "BCDEFIJ";

      // Reset state
      #2 reset_n = 1'b0;
      #1;
      chk("rst_lives0", lives, 0);
      chk("rst_vld0", result_valid, 0);
      chk("rst_res0", result, 0);
      chk("rst_rev0", revealed, 0);
      chk("rst_wl0", {won, lost}, 0);
      chk("rst_rdy0", guess_ready, 0);
      chk("rst_disp0", disp_chars, pk("_______"));
      #14 reset_n = 1'b1;
      step();

      // Load and hit/repeat/invalid
      load("HANGMAN");
      chk("ld_rdy", guess_ready, 1);
      chk("ld_lives", lives, 7);
      chk("ld_disp", disp_chars, pk("_______"));
      chk("ld_rev", revealed, 0);
      guess("a", 2'd0, 7, 7'b0100010);
      chk("hit_disp", disp_chars, pk("_A___A_"));
      guess("A", 2'd2, 7, 7'b0100010);
      guess("3", 2'd3, 7, 7'b0100010);
      chk("inv_disp", disp_chars, pk("_A___A_"));

      // Lose after seven misses
      do_restart();
      load("HANGMAN");
      for (int i = 0; i < 7; i++) guess(misses[i], 2'd1, 6 - i, 7'b0);
      chk("lose_lost", lost, 1);
      chk("lose_won", won, 0);
      chk("lose_disp", disp_chars, pk("HANGMAN"));
      chk("lose_rev", revealed, 0);
      guess_char  = "H";
      guess_valid = 1'b1;
      step();
      guess_valid = 1'b0;
      chk("lose_ign_vld", result_valid, 0);
      chk("lose_ign_rdy", guess_ready, 0);
      chk("lose_sticky", lost, 1);
      chk("lose_res_hold", result, 1);

      // Win, two edges after the final acceptance
      do_restart();
      load("HANGMAN");
      guess("H", 2'd0, 7, 7'b0000001);
      guess("A", 2'd0, 7, 7'b0100011);
      guess("n", 2'd0, 7, 7'b1100111);
      guess("G", 2'd0, 7, 7'b1101111);
      guess("M", 2'd0, 7, 7'b1111111);
      chk("win_won", won, 1);
      chk("win_lives", lives, 7);
      chk("win_disp", disp_chars, pk("HANGMAN"));
      load_valid = 1'b1;
      word_in    = pk("ZZZZZZZ");
      step();
      load_valid = 1'b0;
      chk("win_sticky", won, 1);
      chk("win_ld_ign", disp_chars, pk("HANGMAN"));

      // Spaces revealed at load
      do_restart();
      chk("rst_won", won, 0);
      load("AB CD  ");
      chk("sp_rev", revealed, 7'b1100100);
      chk("sp_disp", disp_chars, pk("__ __  "));
      guess("A", 2'd0, 7, 7'b1100101);
      guess("b", 2'd0, 7, 7'b1100111);
      guess("Q", 2'd1, 6, 7'b1100111);
      guess("C", 2'd0, 6, 7'b1101111);
      guess("D", 2'd0, 6, 7'b1111111);
      chk("sp_won", won, 1);
      chk("sp_disp_w", disp_chars, pk("AB CD  "));

      // Restart beats a simultaneous guess
      do_restart();
      load("HANGMAN");
      guess_char  = "H";
      guess_valid = 1'b1;
      restart     = 1'b1;
      step();
      guess_valid = 1'b0;
      restart     = 1'b0;
      chk("rg_vld", result_valid, 0);
      chk("rg_rdy", guess_ready, 0);
      chk("rg_lives", lives, 0);
      chk("rg_rev", revealed, 0);

      // Asynchronous reset mid-game
      load("HANGMAN");
      guess("Z", 2'd1, 6, 7'b0);
      guess("A", 2'd0, 6, 7'b0100010);
      #3 reset_n = 1'b0;
      #1;
      chk("ar_lives", lives, 0);
      chk("ar_rev", revealed, 0);
      chk("ar_rdy", guess_ready, 0);
      chk("ar_disp", disp_chars, pk("_______"));
      #2 reset_n = 1'b1;
      step();
      chk("ar_idle", guess_ready, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hangman_core.md
Name: hangman_core

Overview:
- Parametrised game engine for the ASCII word-guessing display path. Replaces the fixed 7-slot comparator bank and the free-running lives register.
- Holds one secret word of WORD_LEN characters and accepts guesses through a valid/ready handshake. Tracks which letters have been used and counts lives down on misses.
- Outputs a masked character vector for the text renderer, plus win/lose status for the seven-segment and VGA layers.

Parameters:
- WORD_LEN, 7, number of character slots in the word.
- CHAR_W, 7, ASCII code width in bits.
- MAX_LIVES, 7, lives loaded at game start (1..2^LIFE_W-1).
- LIFE_W, 3, width of the lives counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous, single-cycle, debounced pulse; abort game, return to IDLE.
- load_valid  in  1  word_in valid; sampled only in IDLE.
- word_in  in  WORD_LEN*CHAR_W  secret word; slot 0 is in the LSBs.
- guess_valid  in  1  guess offered.
- guess_char  in  CHAR_W  guessed ASCII code.
- guess_ready  out  1  high only in PLAY.
- disp_chars  out  WORD_LEN*CHAR_W  per slot: the revealed char, or 0x5F ('_') while hidden.
- revealed  out  WORD_LEN  per-slot reveal mask.
- lives  out  LIFE_W  remaining lives.
- result_valid  out  1  one-cycle pulse per accepted guess.
- result  out  2  0=HIT, 1=MISS, 2=REPEAT, 3=INVALID; held until the next pulse.
- won  out  1  high in WIN state.
- lost  out  1  high in LOSE state.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State=IDLE.
  - Word regs, revealed, used-letter mask (26 bits) and result are cleared.
  - lives=0, result_valid=0, won=lost=0.
- States:
  - IDLE: wait for a word.
  - PLAY: accept guesses.
  - CHECK: one evaluation cycle.
  - WIN, LOSE: game over.
- Classification (applies to word chars and guess chars):
  - 'a'-'z' fold to 'A'-'Z'; letter index = folded code - 0x41.
  - Any other code is a non-letter.
- IDLE:
  - load_valid=1 stores word_in with letters folded.
  - Non-letter slots get revealed=1 immediately; letter slots get revealed=0.
  - Used mask cleared, lives=MAX_LIVES, next state CHECK.
- PLAY:
  - Acceptance = guess_valid & guess_ready (edge N).
  - At edge N, result_valid=1 during cycle N+1 and state becomes CHECK.
  - Non-letter guess: INVALID; no change to any other register.
  - Letter already in used mask: REPEAT; no change.
  - New letter matching at least one slot: HIT; set used bit; set revealed on every matching slot in the same edge.
  - New letter matching no slot: MISS; set used bit; lives-1.
- CHECK (one cycle, guess_ready=0):
  - All revealed -> WIN.
  - Else lives==0 -> LOSE.
  - Else -> PLAY.
  - WIN takes priority when both hold.
  - Guess-to-won/lost latency is 2 edges. Maximum guess rate is 1 per 2 cycles.
- WIN / LOSE:
  - Sticky until restart. guess_valid and load_valid are ignored.
  - On LOSE, disp_chars shows all slots unmasked; revealed is unchanged.
- restart:
  - Any state -> IDLE. Clears word, revealed, used mask, lives and result.
  - Beats a simultaneous load_valid or guess (the guess is not accepted; no result_valid).
- Lives never underflow: a MISS is only possible when lives>=1.
- load_valid outside IDLE is ignored.
- All outputs are registered except guess_ready, won and lost, which are decoded from the state register.

Decomposition:
- Package hangman_pkg holds:
  - the state encoding;
  - the result codes;
  - ASCII constants: ASCII_A=0x41, ASCII_a=0x61, ASCII_UNDERSCORE=0x5F;
  - the alphabet size, 26.
- One sub-module, char_classify, combinational. Inputs: CHAR_W code. Outputs: is_letter, folded code, 5-bit index.
  - Instanced once on guess_char.
  - Instanced WORD_LEN times on word_in via generate.

Test Plan:
- Reset, then load "HANGMAN" -> after 2 edges state PLAY, lives=7, disp_chars all '_', guess_ready=1.
- Guess 'a' -> result HIT, revealed=0b0100010 (slots 1,5), lives=7; guess 'A' again -> REPEAT, lives=7; guess '3' -> INVALID, nothing changes.
- Load "HANGMAN", guess 7 distinct non-member letters (B,C,D,E,F,I,J) -> lives 6..0; after the 7th guess the CHECK cycle gives lost=1 and disp_chars="HANGMAN"; a further guess_valid is ignored with guess_ready=0.
- Guess H,A,N,G,M in sequence -> won=1 exactly 2 edges after the 'M' acceptance; lives=7.
- Load "AB CD  " (spaces) -> spaces revealed at load; guessing A,B,C,D -> WIN.
- restart asserted together with guess_valid in PLAY -> no result_valid; next cycle IDLE, lives=0. Also assert reset_n low mid-game between clock edges -> outputs clear without waiting for a clk edge.
